gpio_cycle_sequencer: RTL and testbench



---
 rtl/gpioseq_pkg.sv | 35 +++
 rtl/gpioseq_timer.sv | 28 ++
 rtl/gpio_cycle_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_gpio_cycle_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpioseq_pkg.sv
// Shared types and default timing for the GPIO cycle sequencer.
// The optional ack watchdog is enabled by defining GPIOSEQ_WATCHDOG_EN.
package gpioseq_pkg;

    localparam int SETUP_D   = 4;
    localparam int CLKHI_D   = 8;
    localparam int HOLD_D    = 2;
    localparam int SETTLE_D  = 8;
    localparam int RSTHOLD_D = 16;
    localparam int WDOG_D    = 1024;

    // Wide enough for the longest load, the watchdog interval.
    localparam int TIMER_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_CLKH,
        ST_CLKL,
        ST_RELEASE,
        ST_SAMPLE,
        ST_MEMWAIT,
        ST_IOWAIT
    } seq_state_t;

    typedef struct packed {
        logic        link;
        logic [11:0] data;
    } word_t;

    function automatic logic [TIMER_W-1:0] load_val(input int n);
        return TIMER_W'(n - 1);
    endfunction

endpackage

// File: rtl/gpioseq_timer.sv
// Loadable down-counter with a zero flag; one instance is shared by every
// timed sequencer state, including the optional ack watchdog.
module gpioseq_timer
    import gpioseq_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_cnt;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TIMER_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gpio_cycle_sequencer.sv
// Drives the tube processor pins: clock cycles, DATA/LINK turnaround, memory and IO service.
// Defining GPIOSEQ_WATCHDOG_EN adds the ack timeout that raises ERR and halts.
module gpio_cycle_sequencer
    import gpioseq_pkg::*;
#(
    parameter int SETUP   = SETUP_D,
    parameter int CLKHI   = CLKHI_D,
    parameter int HOLD    = HOLD_D,
    parameter int SETTLE  = SETTLE_D,
    parameter int RSTHOLD = RSTHOLD_D,
    parameter int WDOG    = WDOG_D
) (
    input  logic        FIFTYMHZ,
    input  logic        RESET,
    input  logic        RUN,
    input  logic        STEP,
    input  logic        IRQ,
    output logic        _CLOCK,
    output logic        _DENA,
    output logic        _INTRQ,
    output logic        _IOSKP,
    output logic        _RESET,
    inout  wire  [11:0] DATA,
    inout  wire         LINK,
    input  logic        HALT,
    input  logic        INTAK,
    input  logic        _IOINST,
    input  logic        MREAD,
    input  logic        MWRITE,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [11:0] MEM_ADDR,
    output logic [12:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [12:0] MEM_RDATA,
    output logic        IO_REQ,
    output logic [11:0] IO_OPC,
    output logic [12:0] IO_AC,
    input  logic        IO_ACK,
    input  logic        IO_SKP,
    input  logic [12:0] IO_RDATA,
    output logic        HALTED,
    output logic        BUSY,
    output logic        ERR
);

    localparam int RST_W = $clog2(RSTHOLD + 1);

    seq_state_t         r_state, w_next;
    word_t              r_drv, w_s;
    logic [11:0]        r_lastaddr;
    logic [RST_W-1:0]   r_rst_cnt;
    logic               r_step_d, r_step_cycle, r_halted, r_skip, r_intrq_n;
    logic               r_mem_req, r_mem_we, r_io_req;
    logic [11:0]        r_mem_addr, r_io_opc;
    word_t              r_mem_wdata, r_io_ac;
    logic               w_run_ok, w_tmr_zero, w_tmr_load, w_bus_oe;
    logic [TIMER_W-1:0] w_tmr_val;
    seq_state_t         w_cont;
    logic               w_unused;

    assign w_run_ok = (r_rst_cnt == '0);
    assign w_s      = {~LINK, ~DATA};
    assign w_cont   = (r_step_cycle || !RUN) ? ST_IDLE : ST_DRIVE;
    assign w_unused = INTAK;

    gpioseq_timer u_timer (
        .i_clk      (FIFTYMHZ),
        .i_rst      (RESET),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge FIFTYMHZ) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_run_ok && ((RUN && !r_halted) || STEP)) w_next = ST_DRIVE;
            ST_DRIVE:   if (w_tmr_zero) w_next = ST_CLKH;
            ST_CLKH:    if (w_tmr_zero) w_next = ST_CLKL;
            ST_CLKL:    if (w_tmr_zero) w_next = ST_RELEASE;
            ST_RELEASE: if (w_tmr_zero) w_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (HALT)                 w_next = ST_IDLE;
                else if (MREAD || MWRITE) w_next = ST_MEMWAIT;
                else if (!_IOINST)        w_next = ST_IOWAIT;
                else                      w_next = w_cont;
            end
            ST_MEMWAIT: begin
                if (MEM_ACK) w_next = w_cont;
`ifdef GPIOSEQ_WATCHDOG_EN
                else if (w_tmr_zero) w_next = ST_IDLE;
`endif
            end
            ST_IOWAIT: begin
                if (IO_ACK) w_next = w_cont;
`ifdef GPIOSEQ_WATCHDOG_EN
                else if (w_tmr_zero) w_next = ST_IDLE;
`endif
            end
            default:    w_next = ST_IDLE;
        endcase

        // Reload the shared timer on every state change with the new state's interval.
        w_tmr_load = (w_next != r_state);
        case (w_next)
            ST_DRIVE:              w_tmr_val = load_val(SETUP);
            ST_CLKH:               w_tmr_val = load_val(CLKHI);
            ST_CLKL:               w_tmr_val = load_val(HOLD);
            ST_RELEASE:            w_tmr_val = load_val(SETTLE);
            ST_MEMWAIT, ST_IOWAIT: w_tmr_val = load_val(WDOG);
            default:               w_tmr_val = '0;
        endcase
    end

    always_comb begin
        _CLOCK   = 1'b1;
        _DENA    = 1'b1;
        w_bus_oe = 1'b0;
        case (r_state)
            ST_DRIVE, ST_CLKL: w_bus_oe = 1'b1;
            ST_CLKH: begin
                _CLOCK   = 1'b0;
                w_bus_oe = 1'b1;
            end
            ST_RELEASE, ST_SAMPLE, ST_MEMWAIT, ST_IOWAIT: _DENA = 1'b0;
            default: ;
        endcase
        BUSY = (r_state != ST_IDLE);
    end

    assign DATA = w_bus_oe ? ~r_drv.data : 12'bz;
    assign LINK = w_bus_oe ? ~r_drv.link : 1'bz;

`ifdef GPIOSEQ_WATCHDOG_EN
    logic r_err;
    always_ff @(posedge FIFTYMHZ) begin
        if (RESET)
            r_err <= 1'b0;
        else if ((r_state == ST_MEMWAIT && !MEM_ACK && w_tmr_zero) ||
                 (r_state == ST_IOWAIT  && !IO_ACK  && w_tmr_zero))
            r_err <= 1'b1;
    end
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge FIFTYMHZ) begin
        if (RESET) begin
            r_rst_cnt    <= RST_W'(RSTHOLD);
            r_step_d     <= 1'b0;
            r_step_cycle <= 1'b0;
            r_drv        <= '0;
            r_lastaddr   <= '0;
            r_halted     <= 1'b0;
            r_skip       <= 1'b0;
            r_intrq_n    <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_io_req     <= 1'b0;
            r_io_opc     <= '0;
            r_io_ac      <= '0;
        end else begin
            r_step_d <= STEP;
            if (!w_run_ok) r_rst_cnt <= r_rst_cnt - RST_W'(1);
            if (w_run_ok && STEP && !r_step_d) r_halted <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_intrq_n <= ~IRQ;
                    if (w_next == ST_DRIVE) r_step_cycle <= STEP;
                end
                ST_SAMPLE: begin
                    r_intrq_n <= ~IRQ;
                    r_skip    <= 1'b0;
                    if (HALT) begin
                        r_halted <= 1'b1;
                        r_drv    <= '0;
                    end else if (MREAD) begin
                        r_lastaddr <= w_s.data;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_s.data;
                    end else if (MWRITE) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_lastaddr;
                        r_mem_wdata <= w_s;
                    end else if (!_IOINST) begin
                        r_io_req <= 1'b1;
                        r_io_opc <= w_s.data;
                        r_io_ac  <= w_s;
                    end else begin
                        r_drv <= '0;
                    end
                end
                ST_MEMWAIT: begin
                    if (MEM_ACK) begin
                        r_mem_req <= 1'b0;
                        r_drv     <= r_mem_we ? r_mem_wdata : MEM_RDATA;
                    end
`ifdef GPIOSEQ_WATCHDOG_EN
                    else if (w_tmr_zero) begin
                        r_mem_req <= 1'b0;
                        r_halted  <= 1'b1;
                    end
`endif
                end
                ST_IOWAIT: begin
                    if (IO_ACK) begin
                        r_io_req <= 1'b0;
                        r_drv    <= IO_RDATA;
                        r_skip   <= IO_SKP;
                    end
`ifdef GPIOSEQ_WATCHDOG_EN
                    else if (w_tmr_zero) begin
                        r_io_req <= 1'b0;
                        r_halted <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign _RESET    = w_run_ok;
    assign _INTRQ    = r_intrq_n;
    assign _IOSKP    = ~r_skip;
    assign MEM_REQ   = r_mem_req;
    assign MEM_WE    = r_mem_we;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign IO_REQ    = r_io_req;
    assign IO_OPC    = r_io_opc;
    assign IO_AC     = r_io_ac;
    assign HALTED    = r_halted;

endmodule

// File: tb/tb_gpio_cycle_sequencer.sv
// Directed-vector bench for gpio_cycle_sequencer; the bench plays the processor on the pin side.
// Watchdog vectors are included only when GPIOSEQ_WATCHDOG_EN is defined.
module tb_gpio_cycle_sequencer;

    localparam int SEL_MEMREQ = 0;
    localparam int SEL_IOREQ  = 1;
    localparam int SEL_CLOCK  = 2;
    localparam int SEL_BUSY   = 3;
    localparam int SEL_HALTED = 4;

    logic        clk = 1'b0;
    logic        rst, run, step, irq;
    logic        halt, intak, ioinst_n, mread, mwrite;
    logic        mem_ack, io_ack, io_skp;
    logic [12:0] mem_rdata, io_rdata;
    logic        clock_n, dena_n, intrq_n, ioskp_n, reset_n;
    logic        mem_req, mem_we, io_req, halted, busy, err;
    logic [11:0] mem_addr, io_opc;
    logic [12:0] mem_wdata, io_ac;
    logic [11:0] p_data;
    logic        p_link;
    wire  [11:0] data;
    wire         link;

    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    // The processor drives the bus only while the sequencer has released it.
    assign data = dena_n ? 12'bz : p_data;
    assign link = dena_n ? 1'bz  : p_link;

    gpio_cycle_sequencer dut (
        .FIFTYMHZ  (clk),
        .RESET     (rst),
        .RUN       (run),
        .STEP      (step),
        .IRQ       (irq),
        ._CLOCK    (clock_n),
        ._DENA     (dena_n),
        ._INTRQ    (intrq_n),
        ._IOSKP    (ioskp_n),
        ._RESET    (reset_n),
        .DATA      (data),
        .LINK      (link),
        .HALT      (halt),
        .INTAK     (intak),
        ._IOINST   (ioinst_n),
        .MREAD     (mread),
        .MWRITE    (mwrite),
        .MEM_REQ   (mem_req),
        .MEM_WE    (mem_we),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .MEM_ACK   (mem_ack),
        .MEM_RDATA (mem_rdata),
        .IO_REQ    (io_req),
        .IO_OPC    (io_opc),
        .IO_AC     (io_ac),
        .IO_ACK    (io_ack),
        .IO_SKP    (io_skp),
        .IO_RDATA  (io_rdata),
        .HALTED    (halted),
        .BUSY      (busy),
        .ERR       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o (octal)", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic step_pulse();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            SEL_MEMREQ: return mem_req;
            SEL_IOREQ:  return io_req;
            SEL_CLOCK:  return clock_n;
            SEL_BUSY:   return busy;
            SEL_HALTED: return halted;
            default:    return 1'b0;
        endcase
    endfunction

    // Bounded wait; also reports ticks taken and how many samples had the clock high (_CLOCK low).
    task automatic wait_for(input string tag, input int sel, input logic val,
                            output int n, output int clk_hi);
        n      = 0;
        clk_hi = 0;
        while (sig(sel) !== val && n < 2000) begin
            tick();
            n++;
            if (!clock_n) clk_hi++;
        end
        check(tag, 32'(sig(sel)), 32'(val));
    endtask

    initial begin
        int          n, hi, pulses;
        logic        prev;
        logic [11:0] exp_d;

        rst = 1'b1; run = 1'b0; step = 1'b0; irq = 1'b0;
        halt = 1'b0; intak = 1'b0; ioinst_n = 1'b1; mread = 1'b0; mwrite = 1'b0;
        mem_ack = 1'b0; io_ack = 1'b0; io_skp = 1'b0;
        mem_rdata = '0; io_rdata = '0; p_data = '0; p_link = 1'b0;

        // Reset held for three ticks, then the sixteen-tick _RESET tail.
        tick();
        check("rst_reset_n", reset_n, 0);
        check("rst_clock_n", clock_n, 1);
        check("rst_dena_n", dena_n, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_io_req", io_req, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        ticks(2);
        rst = 1'b0;
        step_pulse();
        check("step_ignored_in_rsthold", busy, 0);
        ticks(14);
        check("reset_n_tick15", reset_n, 0);
        tick();
        check("reset_n_tick16", reset_n, 1);

        // Single-stepped memory read of 0200.
        mread = 1'b1; p_data = ~12'o0200; p_link = 1'b1;
        step_pulse();
        check("step_busy", busy, 1);
        wait_for("rd_req", SEL_MEMREQ, 1'b1, n, hi);
        check("cycle_latency", n, 23);
        check("clkhi_ticks", hi, 8);
        check("rd_addr", mem_addr, 12'o0200);
        check("rd_we", mem_we, 0);
        ticks(3);
        check("rd_req_held", mem_req, 1);
        mem_rdata = 13'o05200; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mread = 1'b0;
        check("rd_req_drop", mem_req, 0);
        check("rd_step_idle", busy, 0);

        // Next cycle drives the read data back during the clock-high phase.
        step_pulse();
        wait_for("rd_clkh", SEL_CLOCK, 1'b0, n, hi);
        exp_d = ~12'o5200;
        check("drv_data", data, exp_d);
        check("drv_link", link, 1);
        wait_for("rd2_end", SEL_BUSY, 1'b0, n, hi);

        // Read of 0300, then a write lands on that address.
        mread = 1'b1; p_data = ~12'o0300;
        step_pulse();
        wait_for("rd300_req", SEL_MEMREQ, 1'b1, n, hi);
        check("rd300_addr", mem_addr, 12'o0300);
        mem_rdata = '0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mread = 1'b0; mwrite = 1'b1;
        p_data = ~12'o0017; p_link = 1'b0;
        step_pulse();
        wait_for("wr_req", SEL_MEMREQ, 1'b1, n, hi);
        check("wr_we", mem_we, 1);
        check("wr_addr", mem_addr, 12'o0300);
        check("wr_wdata", mem_wdata, 13'o10017);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;

        // MREAD and MWRITE together: the read wins.
        mread = 1'b1; p_data = ~12'o0444; p_link = 1'b1;
        step_pulse();
        wait_for("both_req", SEL_MEMREQ, 1'b1, n, hi);
        check("both_we", mem_we, 0);
        check("both_addr", mem_addr, 12'o0444);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mread = 1'b0; mwrite = 1'b0;

        // IO instruction 6032 with skip.
        ioinst_n = 1'b0; p_data = ~12'o6032; p_link = 1'b1;
        step_pulse();
        wait_for("io_req", SEL_IOREQ, 1'b1, n, hi);
        check("io_opc", io_opc, 12'o6032);
        check("io_ac", io_ac, 13'o06032);
        check("io_no_memreq", mem_req, 0);
        io_rdata = 13'o00123; io_skp = 1'b1; io_ack = 1'b1;
        tick();
        io_ack = 1'b0; io_skp = 1'b0; ioinst_n = 1'b1;
        check("io_req_drop", io_req, 0);
        check("ioskp_after_ack", ioskp_n, 0);
        step_pulse();
        wait_for("skp_clkh", SEL_CLOCK, 1'b0, n, hi);
        check("ioskp_next_cycle", ioskp_n, 0);
        exp_d = ~12'o0123;
        check("io_rdata_drv", data, exp_d);
        wait_for("skp_end", SEL_BUSY, 1'b0, n, hi);
        check("ioskp_cleared", ioskp_n, 1);

        // _INTRQ follows IRQ in IDLE, is frozen mid-cycle.
        irq = 1'b1;
        tick();
        check("intrq_idle_set", intrq_n, 0);
        irq = 1'b0;
        tick();
        check("intrq_idle_clr", intrq_n, 1);
        step_pulse();
        wait_for("irq_clkh", SEL_CLOCK, 1'b0, n, hi);
        irq = 1'b1;
        tick();
        check("intrq_frozen", intrq_n, 1);
        wait_for("irq_end", SEL_BUSY, 1'b0, n, hi);
        check("intrq_late", intrq_n, 0);
        irq = 1'b0;
        tick();

        // Free run, HALT raised during the fifth cycle.
        run = 1'b1;
        pulses = 0;
        prev = clock_n;
        for (int i = 0; i < 400 && !halted; i++) begin
            tick();
            if (prev && !clock_n) begin
                pulses++;
                if (pulses == 5) halt = 1'b1;
            end
            prev = clock_n;
        end
        check("run_halted", halted, 1);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (prev && !clock_n) pulses++;
            prev = clock_n;
        end
        check("run_pulses", pulses, 5);
        check("run_halt_idle", busy, 0);
        halt = 1'b0; run = 1'b0;
        step_pulse();
        check("step_clears_halted", halted, 0);
        check("step_after_halt_busy", busy, 1);
        wait_for("halt_step_end", SEL_BUSY, 1'b0, n, hi);

        // Reset during the clock-high phase aborts the cycle.
        step_pulse();
        wait_for("abort_clkh", SEL_CLOCK, 1'b0, n, hi);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_clock_n", clock_n, 1);
        check("abort_dena_n", dena_n, 1);
        check("abort_busy", busy, 0);
        ticks(16);
        check("abort_reset_n", reset_n, 1);

        // Reset during MEMWAIT; a late ack is ignored.
        mread = 1'b1; p_data = ~12'o0100;
        step_pulse();
        wait_for("abort_rd_req", SEL_MEMREQ, 1'b1, n, hi);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_req_drop", mem_req, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; mread = 1'b0;
        check("late_ack_req", mem_req, 0);
        check("late_ack_busy", busy, 0);
        ticks(16);

`ifdef GPIOSEQ_WATCHDOG_EN
        // Withheld ack trips the watchdog on the 1024th MEMWAIT tick.
        mread = 1'b1; p_data = ~12'o0500;
        step_pulse();
        wait_for("wd_req", SEL_MEMREQ, 1'b1, n, hi);
        wait_for("wd_drop", SEL_MEMREQ, 1'b0, n, hi);
        check("wd_ticks", n, 1024);
        check("wd_err", err, 1);
        check("wd_halted", halted, 1);
        check("wd_idle", busy, 0);
        mread = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
